// File: rtl/sm83_bus_pkg.sv
// Shared types for the sm83 external memory port arbiter.
package sm83_bus_pkg;

  localparam int         BUS_AW           = 16;
  localparam int         BUS_DW           = 8;
  localparam logic [7:0] OPEN_BUS_DEFAULT = 8'hff;

  // Owner of the current M-cycle slot on the memory port.
  typedef enum logic [1:0] {
    BM_NONE = 2'd0,
    BM_CPU  = 2'd1,
    BM_DMA  = 2'd2,
    BM_DBG  = 2'd3
  } bus_master_t;

  // One request-side master (DMA or debug peek/poke).
  typedef struct packed {
    logic              req;
    logic [BUS_AW-1:0] adr;
    logic              we;
    logic [BUS_DW-1:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/sm83_bus_rr2.sv
// Two-way round-robin picker between the DMA (a) and debug (b) masters.
// A busy master (already served and still holding its request, or finishing
// its slot at this boundary) is masked out so a held request is not repeated.
module sm83_bus_rr2 (
  input  logic req_a,
  input  logic req_b,
  input  logic busy_a,
  input  logic busy_b,
  input  logic last_a,
  output logic gnt_a,
  output logic gnt_b
);

  logic elig_a;
  logic elig_b;

  // Mask out busy masters, then break a tie against the last one served.
  always_comb begin
    elig_a = req_a & ~busy_a;
    elig_b = req_b & ~busy_b;
    gnt_a  = elig_a & (~elig_b | ~last_a);
    gnt_b  = elig_b & (~elig_a |  last_a);
  end

endmodule

// File: rtl/sm83_bus_arbiter.sv
// Shares the single external memory port between the CPU, a DMA engine and
// the debug peek/poke path. Ownership changes only at the ncyc slot boundary;
// the CPU is never stalled, it just reads OPEN_BUS and loses its writes when
// another master owns the slot.
//
// Handshake (DMA and debug alike): the master raises req with adr/we/wdata
// stable and keeps them stable until it sees the one-clk ack pulse. The ack
// arrives one clk after the boundary that ends the granted slot; read data is
// valid with ack and held until the next ack. Dropping req early does not
// cancel a granted slot: the access completes and ack still pulses.
module sm83_bus_arbiter
  import sm83_bus_pkg::*;
#(
  parameter int            AW       = BUS_AW,
  parameter int            DW       = BUS_DW,
  parameter logic [DW-1:0] OPEN_BUS = OPEN_BUS_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ncyc,
  input  logic [AW-1:0] cpu_adr,
  input  logic          cpu_rd,
  input  logic          cpu_wr,
  input  logic [DW-1:0] cpu_dout,
  output logic [DW-1:0] cpu_din,
  output logic          cpu_conflict,
  input  logic          dma_req,
  input  logic [AW-1:0] dma_adr,
  input  logic          dma_we,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_ack,
  output logic [DW-1:0] dma_rdata,
  input  logic          dbg_req,
  input  logic [AW-1:0] dbg_adr,
  input  logic          dbg_we,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_ack,
  output logic [DW-1:0] dbg_rdata,
  output logic [AW-1:0] mem_adr,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output bus_master_t   grant_state
);

  bus_master_t grant;
  bus_master_t rr_last;
  bus_master_t ack_pend;
  logic        served_dma;
  logic        served_dbg;
  logic        busy_dma;
  logic        busy_dbg;
  logic        gnt_dma;
  logic        gnt_dbg;
  bus_req_t    dma_r;
  bus_req_t    dbg_r;

  assign dma_r = '{req: dma_req, adr: dma_adr, we: dma_we, wdata: dma_wdata};
  assign dbg_r = '{req: dbg_req, adr: dbg_adr, we: dbg_we, wdata: dbg_wdata};

  assign grant_state = grant;
  assign dma_ack     = (ack_pend == BM_DMA);
  assign dbg_ack     = (ack_pend == BM_DBG);

  // A master is ineligible while its held request was already served, and
  // also at the very boundary that ends its own slot.
  always_comb begin
    busy_dma = served_dma | (grant == BM_DMA);
    busy_dbg = served_dbg | (grant == BM_DBG);
  end

  sm83_bus_rr2 u_rr2 (
    .req_a  (dma_r.req),
    .req_b  (dbg_r.req),
    .busy_a (busy_dma),
    .busy_b (busy_dbg),
    .last_a (rr_last == BM_DMA),
    .gnt_a  (gnt_dma),
    .gnt_b  (gnt_dbg)
  );

  // Slot boundary: queue the ack of the finishing slot and load the next owner.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant    <= BM_NONE;
      rr_last  <= BM_DBG;
      ack_pend <= BM_NONE;
    end else begin
      ack_pend <= BM_NONE;
      if (ncyc) begin
        if (grant == BM_DMA || grant == BM_DBG) ack_pend <= grant;
        if (gnt_dma) begin
          grant   <= BM_DMA;
          rr_last <= BM_DMA;
        end else if (gnt_dbg) begin
          grant   <= BM_DBG;
          rr_last <= BM_DBG;
        end else begin
          grant   <= BM_CPU;
        end
      end
    end
  end

  // Capture read data at the end of a DMA/debug read slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dma_rdata <= '0;
      dbg_rdata <= '0;
    end else if (ncyc) begin
      if (grant == BM_DMA && !dma_r.we) dma_rdata <= mem_rdata;
      if (grant == BM_DBG && !dbg_r.we) dbg_rdata <= mem_rdata;
    end
  end

  // Served flags: set when a held request finishes, cleared once req is seen low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      served_dma <= 1'b0;
      served_dbg <= 1'b0;
    end else begin
      if (!dma_req)                         served_dma <= 1'b0;
      else if (ncyc && grant == BM_DMA)     served_dma <= 1'b1;
      if (!dbg_req)                         served_dbg <= 1'b0;
      else if (ncyc && grant == BM_DBG)     served_dbg <= 1'b1;
    end
  end

  // Memory port mux driven by the current slot owner.
  always_comb begin
    mem_adr   = '0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_wdata = '0;
    case (grant)
      BM_CPU: begin
        mem_adr   = cpu_adr;
        mem_rd    = cpu_rd;
        mem_wr    = cpu_wr;
        mem_wdata = cpu_dout;
      end
      BM_DMA: begin
        mem_adr   = dma_r.adr;
        mem_rd    = ~dma_r.we;
        mem_wr    = dma_r.we;
        mem_wdata = dma_r.wdata;
      end
      BM_DBG: begin
        mem_adr   = dbg_r.adr;
        mem_rd    = ~dbg_r.we;
        mem_wr    = dbg_r.we;
        mem_wdata = dbg_r.wdata;
      end
      default: ;
    endcase
  end

  // CPU side: live read data when it owns the slot, open bus and conflict otherwise.
  always_comb begin
    cpu_din      = OPEN_BUS;
    cpu_conflict = 1'b0;
    if (grant == BM_CPU) cpu_din = mem_rdata;
    if (grant == BM_DMA || grant == BM_DBG) cpu_conflict = cpu_rd | cpu_wr;
  end

endmodule

// File: tb/tb_sm83_bus_arbiter.sv
// Self-checking bench for sm83_bus_arbiter: slot-level model plus directed scenarios.
module tb_sm83_bus_arbiter;

  logic        clk, reset, ncyc;
  logic [15:0] cpu_adr;
  logic        cpu_rd, cpu_wr;
  logic [7:0]  cpu_dout, cpu_din;
  logic        cpu_conflict;
  logic        dma_req, dma_we, dma_ack;
  logic [15:0] dma_adr;
  logic [7:0]  dma_wdata, dma_rdata;
  logic        dbg_req, dbg_we, dbg_ack;
  logic [15:0] dbg_adr;
  logic [7:0]  dbg_wdata, dbg_rdata;
  logic [15:0] mem_adr;
  logic        mem_rd, mem_wr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic [1:0]  grant_state;

  logic [7:0]  mem [0:255];
  int          total = 0;
  int          bad = 0;
  int          phase = 0;
  bit          fast = 0;
  bit          cmp_on = 0;

  // model state: owner 0=none 1=cpu 2=dma 3=dbg
  int          m_owner, m_last, m_pend, m_done, m_nxt;
  bit          m_blk2, m_blk3, m_e2, m_e3;
  logic [7:0]  m_rdv2, m_rdv3;
  logic [7:0]  dma_q[$];
  logic [7:0]  dbg_q[$];

  sm83_bus_arbiter dut (
    .clk(clk), .reset(reset), .ncyc(ncyc),
    .cpu_adr(cpu_adr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_dout(cpu_dout),
    .cpu_din(cpu_din), .cpu_conflict(cpu_conflict),
    .dma_req(dma_req), .dma_adr(dma_adr), .dma_we(dma_we), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .dbg_req(dbg_req), .dbg_adr(dbg_adr), .dbg_we(dbg_we), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .mem_adr(mem_adr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .grant_state(grant_state)
  );

  // clock / reset
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // memory model: combinational read, write committed at the slot boundary
  assign mem_rdata = mem[mem_adr[7:0]];
  always @(posedge clk) if (!reset && ncyc && mem_wr) mem[mem_adr[7:0]] <= mem_wdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // slot-level model: who owns each slot, which acks are due and with what data
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_owner = 0; m_last = 3; m_pend = 0;
      m_blk2 = 0; m_blk3 = 0; m_rdv2 = 8'h00; m_rdv3 = 8'h00;
      dma_q.delete(); dbg_q.delete();
    end else begin
      m_done = (ncyc && m_owner >= 2) ? m_owner : 0;
      m_nxt  = m_owner;
      if (ncyc) begin
        m_e2 = dma_req && !m_blk2 && m_done != 2;
        m_e3 = dbg_req && !m_blk3 && m_done != 3;
        if (m_e2 && m_e3) m_nxt = (m_last == 2) ? 3 : 2;
        else if (m_e2)    m_nxt = 2;
        else if (m_e3)    m_nxt = 3;
        else              m_nxt = 1;
      end
      if (m_done == 2) begin
        if (!dma_we) m_rdv2 = mem[dma_adr[7:0]];
        dma_q.push_back(m_rdv2);
      end
      if (m_done == 3) begin
        if (!dbg_we) m_rdv3 = mem[dbg_adr[7:0]];
        dbg_q.push_back(m_rdv3);
      end
      if (!dma_req) m_blk2 = 0; else if (m_done == 2) m_blk2 = 1;
      if (!dbg_req) m_blk3 = 0; else if (m_done == 3) m_blk3 = 1;
      m_pend  = m_done;
      m_owner = m_nxt;
      if (ncyc && m_nxt >= 2) m_last = m_nxt;
    end
  end

  task automatic do_compare();
    logic [15:0] ea;
    logic        erd, ewr;
    logic [7:0]  ew;
    ea = 16'h0; erd = 0; ewr = 0; ew = 8'h0;
    case (m_owner)
      1: begin ea = cpu_adr; erd = cpu_rd;  ewr = cpu_wr; ew = cpu_dout;  end
      2: begin ea = dma_adr; erd = !dma_we; ewr = dma_we; ew = dma_wdata; end
      3: begin ea = dbg_adr; erd = !dbg_we; ewr = dbg_we; ew = dbg_wdata; end
      default: ;
    endcase
    chk("grant", grant_state, m_owner);
    chk("mem_adr", mem_adr, ea);
    chk("mem_rd", mem_rd, erd);
    chk("mem_wr", mem_wr, ewr);
    if (ewr) chk("mem_wdata", mem_wdata, ew);
    chk("cpu_din", cpu_din, (m_owner == 1) ? mem[cpu_adr[7:0]] : 8'hff);
    chk("cpu_conflict", cpu_conflict, (m_owner >= 2) && (cpu_rd || cpu_wr));
    chk("dma_ack", dma_ack, m_pend == 2);
    chk("dbg_ack", dbg_ack, m_pend == 3);
    chk("dma_rdata", dma_rdata, m_rdv2);
    chk("dbg_rdata", dbg_rdata, m_rdv3);
    if (dma_ack) begin
      if (dma_q.size() == 0) chk("dma_ack_unexpected", 1, 0);
      else chk("dma_rdata_q", dma_rdata, dma_q.pop_front());
    end
    if (dbg_ack) begin
      if (dbg_q.size() == 0) chk("dbg_ack_unexpected", 1, 0);
      else chk("dbg_rdata_q", dbg_rdata, dbg_q.pop_front());
    end
  endtask

  // per-cycle compare, sampled 2 time units after the rising edge
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (cmp_on) do_compare();
    end
  end

  // driver tasks: inputs change only on the falling edge
  task automatic tick();
    @(negedge clk);
    phase = (phase + 1) % 4;
    ncyc  = fast || (phase == 3);
  endtask

  task automatic to_slot();
    int  n;
    logic was;
    n = 0;
    do begin
      was = ncyc;
      tick();
      n++;
    end while (!was && n < 12);
    if (!was) chk("slot_timeout", 1, 0);
  endtask

  task automatic count_acks(input int n, output int a_dma, output int a_dbg);
    a_dma = 0; a_dbg = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (dma_ack) a_dma++;
      if (dbg_ack) a_dbg++;
    end
  endtask

  initial begin
    int ad, ab;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 1);
    mem[3] = 8'hb8; mem[5] = 8'h18; mem[7] = 8'h00; mem[8] = 8'h21; mem[9] = 8'h42;
    reset = 1; ncyc = 0;
    cpu_adr = 0; cpu_rd = 0; cpu_wr = 0; cpu_dout = 0;
    dma_req = 0; dma_adr = 0; dma_we = 0; dma_wdata = 0;
    dbg_req = 0; dbg_adr = 0; dbg_we = 0; dbg_wdata = 0;
    #1;
    // reset values
    chk("rst_cpu_din", cpu_din, 8'hff);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_mem_adr", mem_adr, 0);
    chk("rst_conflict", cpu_conflict, 0);
    chk("rst_acks", {dma_ack, dbg_ack}, 0);
    chk("rst_rdata", {dma_rdata, dbg_rdata}, 0);
    cmp_on = 1;
    tick(); tick();
    reset = 0;

    // CPU only
    cpu_rd = 1; cpu_adr = 16'h0003;
    to_slot();
    chk("cpu_read_b8", cpu_din, 8'hb8);
    chk("cpu_read_conflict", cpu_conflict, 0);

    // DMA read steals the slot from a CPU read
    dma_req = 1; dma_adr = 16'h0005; dma_we = 0;
    to_slot();
    chk("dma_slot_adr", mem_adr, 16'h0005);
    chk("dma_slot_cpu_din", cpu_din, 8'hff);
    chk("dma_slot_conflict", cpu_conflict, 1);
    to_slot();
    chk("dma_ack_pulse", dma_ack, 1);
    chk("dma_rdata_18", dma_rdata, 8'h18);
    dma_req = 0;
    tick();
    chk("dma_ack_one_clk", dma_ack, 0);

    // debug write beats a CPU write to the same address
    cpu_rd = 0; cpu_wr = 1; cpu_adr = 16'h0007; cpu_dout = 8'h11;
    dbg_req = 1; dbg_we = 1; dbg_adr = 16'h0007; dbg_wdata = 8'h5a;
    to_slot();
    chk("dbg_wr_conflict", cpu_conflict, 1);
    to_slot();
    chk("dbg_wr_ack", dbg_ack, 1);
    dbg_req = 0; cpu_wr = 0;
    to_slot();
    chk("mem7_is_5a", mem[7], 8'h5a);

    // held DMA request is serviced exactly once
    dma_req = 1; dma_we = 0; dma_adr = 16'h0003;
    count_acks(16, ad, ab);
    chk("held_dma_one_ack", ad, 1);
    chk("held_dma_rdata", dma_rdata, 8'hb8);
    dma_req = 0;

    // debug read with request dropped before ack still completes
    dbg_req = 1; dbg_we = 0; dbg_adr = 16'h0003;
    to_slot();
    dbg_req = 0;
    to_slot();
    chk("dropped_dbg_ack", dbg_ack, 1);
    chk("dropped_dbg_rdata", dbg_rdata, 8'hb8);

    // reset in the middle of a DMA slot
    dma_req = 1; dma_adr = 16'h0005;
    to_slot();
    tick();
    reset = 1;
    #1;
    chk("midrst_mem_rd", mem_rd, 0);
    chk("midrst_mem_adr", mem_adr, 0);
    chk("midrst_cpu_din", cpu_din, 8'hff);
    chk("midrst_dma_ack", dma_ack, 0);
    chk("midrst_dma_rdata", dma_rdata, 0);
    dma_req = 0;
    tick(); tick();
    reset = 0;
    cpu_rd = 1; cpu_adr = 16'h0003;
    to_slot();
    chk("post_rst_grant_cpu", grant_state, 1);
    chk("post_rst_cpu_din", cpu_din, 8'hb8);
    cpu_rd = 0;

    // both requesters from reset: DMA first, then alternate
    dma_req = 1; dma_we = 0; dma_adr = 16'h0008;
    dbg_req = 1; dbg_we = 0; dbg_adr = 16'h0009;
    to_slot();
    chk("rr_first_dma", mem_adr, 16'h0008);
    to_slot();
    chk("rr_dma_rdata", dma_rdata, 8'h21);
    chk("rr_second_dbg", mem_adr, 16'h0009);
    dma_req = 0; tick(); dma_req = 1;
    to_slot();
    chk("rr_dbg_rdata", dbg_rdata, 8'h42);
    chk("rr_third_dma", mem_adr, 16'h0008);
    dbg_req = 0; tick(); dbg_req = 1;
    to_slot();
    chk("rr_fourth_dbg", mem_adr, 16'h0009);
    dma_req = 0; dbg_req = 0;
    to_slot();
    to_slot();

    // back-to-back boundaries: one-clk slots
    fast = 1;
    dma_req = 1; dma_adr = 16'h0005;
    ncyc = 1;
    count_acks(6, ad, ab);
    chk("fast_dma_one_ack", ad, 1);
    chk("fast_dma_rdata", dma_rdata, 8'h18);
    dma_req = 0;
    fast = 0;
    to_slot();
    to_slot();

    cmp_on = 0;
    chk("dma_q_drained", dma_q.size(), 0);
    chk("dbg_q_drained", dbg_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
